// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes and the FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, a result consumer and the arbiter.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic             resp_zero;
    logic             resp_err;

    // Requesters and result consumer
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_result, resp_zero, resp_err
    );

    // Arbiter
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_result, resp_zero, resp_err
    );

endinterface

// File: rtl/alu_exec.sv
// Combinational WIDTH-bit ALU. Unknown op codes yield result 0 with err set.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    // Operation select; add/sub wrap naturally at WIDTH bits
    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result[0] = (a < b);
            ALU_NOR: result = ~(a | b);
            default: err = 1'b1;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one alu_exec: IDLE accepts, EXEC computes,
// RESP holds the result until the consumer takes it.
// Optional macro ALU_ARBITER_RR_EN: round-robin on contention; otherwise
// requester 0 has fixed priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic             grant_id;
    logic             tie_winner;
    logic             ready0;
    logic             ready1;
    logic             accept;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;

    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_err;

    logic [WIDTH-1:0] resp_result_q;
    logic             resp_zero_q;
    logic             resp_err_q;
    logic             resp_id_q;

`ifdef ALU_ARBITER_RR_EN
    logic prio_q;

    // Favour the requester not granted on the last accepted transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (accept) begin
            prio_q <= ~grant_id;
        end
    end

    // Contention winner comes from the round-robin pointer
    always_comb tie_winner = prio_q;
`else
    // Contention winner is always requester 0
    always_comb tie_winner = 1'b0;
`endif

    // A lone valid requester always wins; ties go to tie_winner
    always_comb begin
        grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = tie_winner;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; ready is masked during reset so
    // the ports read 0 while rst is held
    always_comb begin
        state_next = state;
        ready0     = 1'b0;
        ready1     = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    ready0 = bus.req0_valid && !grant_id;
                    ready1 = bus.req1_valid &&  grant_id;
                end
                if (ready0 || ready1) begin
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = ready0 || ready1;

    // Capture the granted operation, then the ALU outcome one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            id_q          <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_id_q     <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= grant_id ? bus.req1_op : bus.req0_op;
                a_q  <= grant_id ? bus.req1_a  : bus.req0_a;
                b_q  <= grant_id ? bus.req1_b  : bus.req0_b;
                id_q <= grant_id;
            end
            if (state == EXEC) begin
                resp_result_q <= alu_result;
                resp_zero_q   <= alu_zero;
                resp_err_q    <= alu_err;
                resp_id_q     <= id_q;
            end
        end
    end

    alu_exec #(
        .WIDTH(WIDTH)
    ) u_alu (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .result(alu_result),
        .zero  (alu_zero),
        .err   (alu_err)
    );

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.resp_valid  = (state == RESP);
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_zero   = resp_zero_q;
    assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected responses are queued when a
// transfer is accepted and popped by a monitor when the result is taken.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic        zero;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   acc_log[$];
    exp_t exp0;
    exp_t exp1;
    exp_t cur;
    exp_t prev;
    exp_t popped;
    bit   held = 1'b0;
    int   checks = 0;
    int   failures = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Acceptance watcher and response monitor
    always @(negedge clk) begin
        if (bus.req0_valid && bus.req0_ready) begin
            sb.push_back(exp0);
            acc_log.push_back(0);
        end
        if (bus.req1_valid && bus.req1_ready) begin
            sb.push_back(exp1);
            acc_log.push_back(1);
        end
        if (bus.resp_valid) begin
            cur = '{bus.resp_id, bus.resp_result, bus.resp_zero, bus.resp_err};
            if (held) begin
                checks++;
                if (cur !== prev) begin
                    failures++;
                    $display("FAIL resp_hold actual=%h required=%h", cur, prev);
                end
            end
            if (bus.resp_ready) begin
                held = 1'b0;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected actual=%h required=none", cur);
                end else begin
                    popped = sb.pop_front();
                    if (cur !== popped) begin
                        failures++;
                        $display("FAIL resp_data actual=%h required=%h", cur, popped);
                    end
                end
            end else begin
                held = 1'b1;
                prev = cur;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic drive(input int id, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r, input logic z, input logic e);
        if (id == 0) begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
            exp0 = '{1'b0, r, z, e};
            bus.req0_valid = 1'b1;
        end else begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
            exp1 = '{1'b1, r, z, e};
            bus.req1_valid = 1'b1;
        end
    endtask

    // Returns at posedge+1 of the accepting edge with valid dropped
    task automatic wait_accept(input int id);
        bit ok = 1'b0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge clk);
            if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (id == 0) bus.req0_valid = 1'b0;
        else         bus.req1_valid = 1'b0;
        check("accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge clk);
            if (sb.size() == 0) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        check("drain_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic send(input int id, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r, input logic z, input logic e);
        drive(id, op, a, b, r, z, e);
        wait_accept(id);
        drain();
    endtask

    function automatic int count_id(input int id);
        int n = 0;
        foreach (acc_log[i]) if (acc_log[i] == id) n++;
        return n;
    endfunction

    initial begin
        int exp_order[$];
        int seen;
        int n0_limit;

        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_op = ALU_ADD; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = ALU_AND; bus.req1_a = '0; bus.req1_b = '0;
        bus.resp_ready = 1'b1;
        exp0 = '0; exp1 = '0;

        // Reset values, with a valid request present
        @(negedge clk);
        check("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_id", {31'd0, bus.resp_id}, 32'd0);
        check("rst_resp_result", bus.resp_result, 32'd0);
        check("rst_resp_zero", {31'd0, bus.resp_zero}, 32'd0);
        check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        bus.req0_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Single request and latency
        drive(0, ALU_ADD, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0);
        @(negedge clk);
        check("single_ready0", {31'd0, bus.req0_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        @(negedge clk);
        check("lat_exec_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("lat_exec_ready0", {31'd0, bus.req0_ready}, 32'd0);
        @(negedge clk);
        check("lat_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("lat_resp_result", bus.resp_result, 32'd12);
        @(posedge clk);
        #1;
        drain();

        // Arithmetic and encoding vectors
        send(0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        send(0, ALU_SLT, 32'h8000_0000, 32'd1, 32'd0, 1'b1, 1'b0);
        send(1, ALU_SLT, 32'd1, 32'd2, 32'd1, 1'b0, 1'b0);
        send(1, ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(1, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
        send(0, ALU_NOR, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(0, ALU_OR, 32'h0000_00A0, 32'h0000_0005, 32'h0000_00A5, 1'b0, 1'b0);
        send(1, 4'b1010, 32'd5, 32'd3, 32'd0, 1'b1, 1'b1);

        // Backpressure with a request waiting
        bus.resp_ready = 1'b0;
        drive(0, ALU_ADD, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0);
        wait_accept(0);
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1;
        end
        check("bp_reach_resp", seen, 1);
        @(posedge clk);
        #1;
        drive(1, ALU_AND, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("bp_result", bus.resp_result, 32'h30);
            check("bp_ready1", {31'd0, bus.req1_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("bp_release_ready1", {31'd0, bus.req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_idle_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("bp_idle_ready1", {31'd0, bus.req1_ready}, 32'd1);
        @(posedge clk);
        #1 bus.req1_valid = 1'b0;
        drain();

        // Contention
        acc_log.delete();
`ifdef ALU_ARBITER_RR_EN
        n0_limit = 1;
        exp_order = '{0, 1};
`else
        n0_limit = 3;
        exp_order = '{0, 0, 0, 1};
`endif
        drive(0, ALU_SUB, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0);
        drive(1, ALU_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0);
        for (int c = 0; c < 60 && (bus.req0_valid || bus.req1_valid); c++) begin
            @(posedge clk);
            #1;
            if (count_id(0) >= n0_limit) bus.req0_valid = 1'b0;
            if (count_id(1) >= 1)        bus.req1_valid = 1'b0;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain();
        check("cont_count", acc_log.size(), exp_order.size());
        for (int i = 0; i < exp_order.size() && i < acc_log.size(); i++) begin
            check("cont_order", acc_log[i], exp_order[i]);
        end

        // Reset while EXEC is in progress
        drive(0, ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
        wait_accept(0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("mid_rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
        rst = 1'b0;
        sb.delete();
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("mid_rst_no_resp", seen, 0);
        @(posedge clk);
        #1;

        acc_log.delete();
        drive(0, ALU_OR, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        drive(1, ALU_SLT, 32'd2, 32'd1, 32'd0, 1'b1, 1'b0);
        for (int c = 0; c < 60 && (bus.req0_valid || bus.req1_valid); c++) begin
            @(posedge clk);
            #1;
            if (count_id(0) >= 1) bus.req0_valid = 1'b0;
            if (count_id(1) >= 1) bus.req1_valid = 1'b0;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain();
        check("post_rst_count", acc_log.size(), 2);
        if (acc_log.size() > 0) check("post_rst_first", acc_log[0], 0);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
